adder_checker: RTL and testbench

- Self-checking stimulus/response engine for the 32-bit adder family (carry_skip and siblings).
- Drives operands a, b, cin into a combinational adder under test and waits a programmable settle time.
- Compares the adder's s/cout against a behavioural a+b+cin, counts mismatches and reports pass/fail.
- It is the driving and checking end of the adder interface: it owns a/b/cin and consumes s/cout.

---
 rtl/adder_checker.sv | 177 +++++++++++++++++
 tb/tb_adder_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_checker.sv
// ---------------------------------------------------------------------------
// adder_checker
//   Stimulus/response engine for a combinational adder under test. It drives
//   a/b/cin, holds them for SETTLE_CYCLES cycles, then checks sum/cout against
//   a behavioural a+b+cin. It counts failing vectors and reports pass/fail.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   start           one-cycle run request (only honoured in IDLE/DONE)
//   a_out, b_out    operands to the adder (WIDTH bits)
//   cin_out         carry-in to the adder
//   sum_in          adder sum, WIDTH+1 bits, MSB is the carry
//   cout_in         adder carry-out
//   busy            run in progress
//   done            run complete, held until next start or rst
//   pass            valid while done, 1 iff err_count==0
//   err_count       failing vectors, saturating at 16'hFFFF
//   first_err_index index of the first failing vector
// ---------------------------------------------------------------------------
module adder_checker #(
    parameter int          WIDTH         = 32,
    parameter int          NUM_VECTORS   = 16,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] SEED_A        = 32'hACE12468,
    parameter logic [31:0] SEED_B        = 32'h13579BDF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             cin_out,
    input  logic [WIDTH:0]   sum_in,
    input  logic             cout_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_index
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_settle;
    logic [15:0] r_idx;
    logic [31:0] r_lfsr_a;
    logic [31:0] r_lfsr_b;

    logic [15:0]      w_next_idx;
    logic [WIDTH-1:0] w_vec_a;
    logic [WIDTH-1:0] w_vec_b;
    logic             w_vec_c;
    logic             w_adv;
    logic [WIDTH:0]   w_expected;
    logic             w_mismatch;
    logic [15:0]      w_err_next;

    // 32-bit Galois LFSR, right shift
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    assign w_next_idx = r_idx + 16'd1;

    // Operands for the vector that follows r_idx. Vector 0 is loaded
    // directly at start, so only indices 1..3 are directed here; anything
    // later comes from the LFSRs, which advance only when consumed.
    always_comb begin
        w_vec_a = r_lfsr_a[WIDTH-1:0];
        w_vec_b = r_lfsr_b[WIDTH-1:0];
        w_vec_c = r_lfsr_a[31] ^ r_lfsr_b[0];
        w_adv   = 1'b1;
        case (w_next_idx)
            16'd1: begin
                w_vec_a = {WIDTH{1'b1}};
                w_vec_b = '0;
                w_vec_c = 1'b1;
                w_adv   = 1'b0;
            end
            16'd2: begin
                w_vec_a = {WIDTH{1'b1}};
                w_vec_b = {WIDTH{1'b1}};
                w_vec_c = 1'b1;
                w_adv   = 1'b0;
            end
            16'd3: begin
                w_vec_a = WIDTH'(32'd41);
                w_vec_b = WIDTH'(32'd3);
                w_vec_c = 1'b1;
                w_adv   = 1'b0;
            end
            default: ;
        endcase
    end

    assign w_expected = {1'b0, a_out} + {1'b0, b_out} + (WIDTH+1)'(cin_out);
    // A bad sum and a bad cout on the same vector still count as one error
    assign w_mismatch = (sum_in != w_expected) || (cout_in != w_expected[WIDTH]);
    assign w_err_next = (w_mismatch && (err_count != 16'hFFFF)) ?
                        err_count + 16'd1 : err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_settle        <= '0;
            r_idx           <= '0;
            r_lfsr_a        <= SEED_A;
            r_lfsr_b        <= SEED_B;
            a_out           <= '0;
            b_out           <= '0;
            cin_out         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_index <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_out           <= '0;
                        b_out           <= '0;
                        cin_out         <= 1'b0;
                        err_count       <= '0;
                        first_err_index <= '0;
                        r_lfsr_a        <= SEED_A;
                        r_lfsr_b        <= SEED_B;
                        r_idx           <= '0;
                        r_settle        <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        r_state         <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_settle == 32'(SETTLE_CYCLES - 1)) begin
                        r_settle <= '0;
                        r_state  <= S_CHECK;
                    end else begin
                        r_settle <= r_settle + 32'd1;
                    end
                end
                S_CHECK: begin
                    err_count <= w_err_next;
                    if (w_mismatch && (err_count == 16'd0))
                        first_err_index <= r_idx;
                    if (r_idx == 16'(NUM_VECTORS - 1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == 16'd0);
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= w_next_idx;
                        a_out   <= w_vec_a;
                        b_out   <= w_vec_b;
                        cin_out <= w_vec_c;
                        if (w_adv) begin
                            r_lfsr_a <= lfsr_step(r_lfsr_a);
                            r_lfsr_b <= lfsr_step(r_lfsr_b);
                        end
                        r_state <= S_SETTLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_checker.sv
// ---------------------------------------------------------------------------
// tb_adder_checker
//   Two checkers (16 and 4 vectors) each drive a behavioural adder model
//   with selectable faults. Expected operands and error counts come from a
//   reference that rebuilds the vector list from the seeds for every index.
// ---------------------------------------------------------------------------
module tb_adder_checker;

    localparam int          SC     = 2;
    localparam logic [31:0] SEED_A = 32'hACE12468;
    localparam logic [31:0] SEED_B = 32'h13579BDF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start16 = 1'b0;
    logic start4  = 1'b0;

    logic [31:0] a16, b16, a4, b4;
    logic        c16, c4;
    logic [32:0] sum16, sum4;
    logic        cout16, cout4;
    logic        busy16, done16, pass16, busy4, done4, pass4;
    logic [15:0] err16, first16, err4, first4;

    int mode16 = 0, j16 = 0, mode4 = 0, j4 = 0;
    int sel = 0;
    int errors = 0;
    int checks = 0;

    logic [31:0] x_a, x_b;
    logic        x_c, x_busy, x_done, x_pass;
    logic [15:0] x_err, x_first;

    always #5 clk = ~clk;

    adder_checker #(.WIDTH(32), .NUM_VECTORS(16), .SETTLE_CYCLES(SC)) dut16 (
        .clk(clk), .rst(rst), .start(start16),
        .a_out(a16), .b_out(b16), .cin_out(c16),
        .sum_in(sum16), .cout_in(cout16),
        .busy(busy16), .done(done16), .pass(pass16),
        .err_count(err16), .first_err_index(first16)
    );

    adder_checker #(.WIDTH(32), .NUM_VECTORS(4), .SETTLE_CYCLES(SC)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .a_out(a4), .b_out(b4), .cin_out(c4),
        .sum_in(sum4), .cout_in(cout4),
        .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .first_err_index(first4)
    );

    // Adder under test: ideal sum, then an optional fault.
    // 1: carry forced 0, 2: sum[0] inverted, 3: sum[0] inverted when a[j]=1
    function automatic logic [33:0] adder(input logic [31:0] a, b, input logic c,
                                          input int mode, input int j);
        logic [32:0] s;
        logic        co;
        s  = {1'b0, a} + {1'b0, b} + {32'b0, c};
        co = s[32];
        case (mode)
            1: begin s[32] = 1'b0; co = 1'b0; end
            2: s[0] = ~s[0];
            3: if (a[j]) s[0] = ~s[0];
            default: ;
        endcase
        return {co, s};
    endfunction

    always_comb {cout16, sum16} = adder(a16, b16, c16, mode16, j16);
    always_comb {cout4, sum4}   = adder(a4, b4, c4, mode4, j4);

    always_comb begin
        if (sel != 0) begin
            x_a = a4; x_b = b4; x_c = c4; x_busy = busy4; x_done = done4;
            x_pass = pass4; x_err = err4; x_first = first4;
        end else begin
            x_a = a16; x_b = b16; x_c = c16; x_busy = busy16; x_done = done16;
            x_pass = pass16; x_err = err16; x_first = first16;
        end
    end

    // Vector k rebuilt from scratch: directed list, then k-4 LFSR steps
    function automatic void get_vec(input int k, output logic [31:0] a, b,
                                    output logic c);
        logic [31:0] sa, sb;
        case (k)
            0: begin a = 32'd0;          b = 32'd0;          c = 1'b0; end
            1: begin a = 32'hFFFFFFFF;   b = 32'd0;          c = 1'b1; end
            2: begin a = 32'hFFFFFFFF;   b = 32'hFFFFFFFF;   c = 1'b1; end
            3: begin a = 32'd41;         b = 32'd3;          c = 1'b1; end
            default: begin
                sa = SEED_A;
                sb = SEED_B;
                for (int i = 0; i < k - 4; i++) begin
                    sa = sa[0] ? ((sa >> 1) ^ 32'h80200003) : (sa >> 1);
                    sb = sb[0] ? ((sb >> 1) ^ 32'h80200003) : (sb >> 1);
                end
                a = sa;
                b = sb;
                c = sa[31] ^ sb[0];
            end
        endcase
    endfunction

    function automatic void model_run(input int nv, input int mode, input int j,
                                      output int errs, output int first);
        logic [31:0] a, b;
        logic        c;
        longint      ideal;
        logic [33:0] got;
        errs  = 0;
        first = 0;
        for (int k = 0; k < nv; k++) begin
            get_vec(k, a, b, c);
            ideal = longint'(a) + longint'(b) + longint'(c);
            got   = adder(a, b, c, mode, j);
            if (got !== {ideal[32], ideal[32:0]}) begin
                if (errs == 0) first = k;
                errs++;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) start4 = v;
        else          start16 = v;
    endtask

    // Start a run on the selected checker and follow it to DONE
    task automatic run(input int nv, input string tag, input bit rand_start);
        logic [31:0] ea, eb;
        logic        ec;
        int          n, errs, first;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        check({tag, " start"}, {x_busy, x_done, x_pass, x_err, x_first},
              {1'b1, 1'b0, 1'b0, 16'd0, 16'd0});
        n = 0;
        while (x_busy && n < 2000) begin
            get_vec(n / (SC + 1), ea, eb, ec);
            check($sformatf("%s op@%0d", tag, n), {x_a, x_b, x_c}, {ea, eb, ec});
            if (sel == 0 && n == 4 * (SC + 1))
                check({tag, " vec4"}, {x_a, x_b, x_c},
                      {32'hACE12468, 32'h13579BDF, 1'b0});
            if (rand_start) set_start($urandom_range(0, 3) == 0);
            tick();
            set_start(1'b0);
            n++;
        end
        check({tag, " busy_cycles"}, n, nv * (SC + 1));
        model_run(nv, (sel != 0) ? mode4 : mode16, (sel != 0) ? j4 : j16,
                  errs, first);
        check({tag, " result"}, {x_done, x_pass, x_err, x_first},
              {1'b1, errs == 0, 16'(errs), 16'(first)});
    endtask

    initial begin
        repeat (3) tick();
        check("reset16", {a16, b16, c16, busy16, done16, pass16, err16, first16}, '0);
        check("reset4", {a4, b4, c4, busy4, done4, pass4, err4, first4}, '0);
        rst = 1'b0;
        tick();

        sel = 0; mode16 = 0;
        run(16, "ideal16", 1'b1);
        check("ideal16 pass", {pass16, err16}, {1'b1, 16'd0});
        tick();
        check("ideal16 done_held", {done16, busy16}, 2'b10);
        run(16, "ideal16_restart", 1'b1);

        sel = 1; mode4 = 1;
        run(4, "carry0", 1'b1);
        check("carry0 fixed", {done4, pass4, err4, first4}, {1'b1, 1'b0, 16'd2, 16'd1});
        run(4, "carry0_restart", 1'b0);
        check("carry0_restart fixed", {done4, pass4, err4, first4},
              {1'b1, 1'b0, 16'd2, 16'd1});

        mode4 = 2;
        run(4, "sum0inv", 1'b0);
        check("sum0inv fixed", {done4, pass4, err4, first4}, {1'b1, 1'b0, 16'd4, 16'd0});

        mode4 = 3; j4 = $urandom_range(0, 31);
        run(4, $sformatf("rand4_j%0d", j4), 1'b1);
        sel = 0; mode16 = 3; j16 = $urandom_range(0, 31);
        run(16, $sformatf("rand16_j%0d", j16), 1'b1);

        // Reset during the settle window of vector 2
        mode16 = 0;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        repeat (2 * (SC + 1)) tick();
        check("pre_rst vec2", {a16, b16, c16}, {32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_rst", {a16, b16, c16, busy16, done16, pass16, err16, first16}, '0);
        tick();
        check("idle_hold", {busy16, done16}, 2'b00);
        run(16, "after_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
